// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: round constants, schedule sigma functions and
// the sequencer state encoding.
package sha256_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    localparam logic [WORD_W-1:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [WORD_W-1:0] k_const(input logic [5:0] t);
        return K_TAB[t];
    endfunction

    function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

endpackage

// File: rtl/sha256_sched_window.sv
// 16-word message schedule window: loaded word by word, then shifted once per
// round with the newly expanded word entering at the top.
module sha256_sched_window
    import sha256_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic [3:0]        load_idx,
    input  logic [WORD_W-1:0] load_word,
    input  logic              shift_en,
    output logic [WORD_W-1:0] w0
);

    logic [WORD_W-1:0] win_q [16];
    logic [WORD_W-1:0] exp_d;

    // W[t+16] from the words currently at offsets 0, 1, 9 and 14.
    assign exp_d = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= '0;
            end
        end else if (shift_en) begin
            for (int i = 0; i < 15; i++) begin
                win_q[i] <= win_q[i+1];
            end
            win_q[15] <= exp_d;
        end else if (load_en) begin
            win_q[load_idx] <= load_word;
        end
    end

    assign w0 = win_q[0];

endmodule

// File: rtl/sha256_kw_sequencer.sv
// Sequences (round, K_t, W_t) beats for one 512-bit block: loads 16 message
// words, then streams ROUNDS beats under consumer back-pressure.
module sha256_kw_sequencer
    import sha256_pkg::*;
#(
    parameter int ROUNDS = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              msg_valid,
    output logic              msg_ready,
    input  logic [WORD_W-1:0] msg_word,
    output logic              kw_valid,
    input  logic              kw_ready,
    output logic [5:0]        kw_round,
    output logic [WORD_W-1:0] kw_k,
    output logic [WORD_W-1:0] kw_w,
    output logic              kw_last,
    output logic              busy
);

    if (ROUNDS < 16 || ROUNDS > 64) begin : g_rounds_chk
        $error("sha256_kw_sequencer: ROUNDS must be within 16..64");
    end

    localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

    state_e     state_q;
    logic [5:0] cnt_q;
    logic [5:0] cnt_d;
    logic       msg_ready_q;
    logic       kw_valid_q;
    logic       busy_q;
    logic       load_en;
    logic       shift_en;

    assign cnt_d    = cnt_q + 6'd1;
    // abort suppresses both window writes so it always wins over a handshake.
    assign load_en  = !abort && (state_q == ST_LOAD) && msg_valid;
    assign shift_en = !abort && kw_valid_q && kw_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            msg_ready_q <= 1'b0;
            kw_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else if (abort) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            msg_ready_q <= 1'b0;
            kw_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q     <= ST_LOAD;
                        cnt_q       <= '0;
                        msg_ready_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (msg_valid) begin
                        if (cnt_q == 6'd15) begin
                            state_q     <= ST_RUN;
                            cnt_q       <= '0;
                            msg_ready_q <= 1'b0;
                            kw_valid_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                end
                ST_RUN: begin
                    if (kw_ready) begin
                        if (cnt_q == LAST_T) begin
                            state_q    <= ST_IDLE;
                            cnt_q      <= '0;
                            kw_valid_q <= 1'b0;
                            busy_q     <= 1'b0;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cnt_q       <= '0;
                    msg_ready_q <= 1'b0;
                    kw_valid_q  <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    sha256_sched_window u_window (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_en   (load_en),
        .load_idx  (cnt_q[3:0]),
        .load_word (msg_word),
        .shift_en  (shift_en),
        .w0        (kw_w)
    );

    assign msg_ready = msg_ready_q;
    assign kw_valid  = kw_valid_q;
    assign kw_round  = cnt_q;
    assign kw_k      = k_const(cnt_q);
    assign kw_last   = kw_valid_q && (cnt_q == LAST_T);
    assign busy      = busy_q;

endmodule
